// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Forwarding and load-use hazard unit for the RV32I pipeline, sitting beside
// EX. It keeps a shift-register scoreboard of the destination registers of the
// DEPTH instructions downstream of EX. Entry 1 is EX/MEM, entry 2 is MEM/WB,
// and so on. From that scoreboard it derives the per-operand forward selects
// and a load-use stall for the instruction currently in EX.
//
// Parameters
//   REG_AW     register address width
//   DEPTH      tracked stages after EX (1..7)
//   LOAD_STAGE first tracked stage from which load data can be forwarded
//              (1..DEPTH)
//   SEL_W      forward select width
//
// Ports
//   clk         single clock
//   rst_n       synchronous active-low reset; clears all scoreboard entries
//   pipe_en     pipeline advance (0 = freeze, scoreboard holds)
//   flush       EX instruction is killed; it is not recorded and cannot stall
//   ex_valid    EX holds a real instruction
//   ex_rs1/rs2  EX source registers
//   ex_rd       EX destination register
//   ex_wb       EX instruction writes rd
//   ex_load     EX instruction is a load
//   fwd_sel1/2  0 = register file, k = forward from tracked stage k
//   stall_o     load-use stall (holds IF/ID/EX, inserts a bubble)
//
// Optional feature, enabled by defining HAZARD_STATS_EN:
//   stall_cnt   number of cycles with stall_o & pipe_en (wraps)
//   fwd_cnt     number of nonzero selects taken on advancing, non-stalled
//               cycles (wraps)
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 2,
   parameter int LOAD_STAGE = 2,
   parameter int SEL_W      = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_en,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_wb,
   input  logic              ex_load,
   output logic [SEL_W-1:0]  fwd_sel1,
   output logic [SEL_W-1:0]  fwd_sel2,
   output logic              stall_o
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       fwd_cnt
`endif
);

   // Scoreboard: index 1 is the youngest tracked stage.
   logic              r_v  [1:DEPTH];
   logic [REG_AW-1:0] r_rd [1:DEPTH];
   logic              r_wb [1:DEPTH];
   logic              r_ld [1:DEPTH];

   logic [SEL_W-1:0]  w_sel1_raw;
   logic [SEL_W-1:0]  w_sel2_raw;
   logic              w_ldhaz1;
   logic              w_ldhaz2;
   logic              w_stall;

   // Only the valid bits need a reset. The payload is ignored while v = 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 1; k <= DEPTH; k++) r_v[k] <= 1'b0;
      end else if (pipe_en) begin
         r_v[1] <= ex_valid & ~flush & ~w_stall;
         for (int k = 2; k <= DEPTH; k++) r_v[k] <= r_v[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (pipe_en) begin
         r_rd[1] <= ex_rd;
         r_wb[1] <= ex_wb;
         r_ld[1] <= ex_load;
         for (int k = 2; k <= DEPTH; k++) begin
            r_rd[k] <= r_rd[k-1];
            r_wb[k] <= r_wb[k-1];
            r_ld[k] <= r_ld[k-1];
         end
      end
   end

   // Scan from oldest to youngest, so the last hit is the youngest producer.
   // A load hit only causes a hazard when it is the youngest match and has
   // not yet reached LOAD_STAGE.
   always_comb begin
      w_sel1_raw = '0;
      w_sel2_raw = '0;
      w_ldhaz1   = 1'b0;
      w_ldhaz2   = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (r_v[k] && r_wb[k] && (r_rd[k] != '0) && (r_rd[k] == ex_rs1)) begin
            w_sel1_raw = SEL_W'(k);
            w_ldhaz1   = r_ld[k] && (k < LOAD_STAGE);
         end
         if (r_v[k] && r_wb[k] && (r_rd[k] != '0) && (r_rd[k] == ex_rs2)) begin
            w_sel2_raw = SEL_W'(k);
            w_ldhaz2   = r_ld[k] && (k < LOAD_STAGE);
         end
      end
   end

   // flush suppresses the stall. While stalled, the selects are parked at 0.
   assign w_stall  = ex_valid & ~flush & (w_ldhaz1 | w_ldhaz2);
   assign stall_o  = w_stall;
   assign fwd_sel1 = (ex_valid && !w_stall) ? w_sel1_raw : '0;
   assign fwd_sel2 = (ex_valid && !w_stall) ? w_sel2_raw : '0;

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fwd_cnt;
   logic [1:0]  w_nfwd;

   assign w_nfwd = {1'b0, (fwd_sel1 != '0)} + {1'b0, (fwd_sel2 != '0)};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else if (pipe_en) begin
         if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
         else         r_fwd_cnt   <= r_fwd_cnt + 32'(w_nfwd);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

   logic       clk = 1'b0;
   logic       rst_n, pipe_en, flush, ex_valid, ex_wb, ex_load;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [1:0] a_sel1, a_sel2, b_sel1, b_sel2;
   logic       a_stall, b_stall;
`ifdef HAZARD_STATS_EN
   logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

   always #5 clk = ~clk;

   // A: DEPTH 2 / LOAD_STAGE 2, B: DEPTH 3 / LOAD_STAGE 3, sharing one EX stream.
   hazard_forward_unit #(.REG_AW(5), .DEPTH(2), .LOAD_STAGE(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush),
      .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_wb(ex_wb), .ex_load(ex_load),
      .fwd_sel1(a_sel1), .fwd_sel2(a_sel2), .stall_o(a_stall)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(a_scnt), .fwd_cnt(a_fcnt)
`endif
   );

   hazard_forward_unit #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush),
      .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_wb(ex_wb), .ex_load(ex_load),
      .fwd_sel1(b_sel1), .fwd_sel2(b_sel2), .stall_o(b_stall)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(b_scnt), .fwd_cnt(b_fcnt)
`endif
   );

   // Reference model: per configuration, a list of in-flight producers
   // (index 1 = youngest) plus the two statistics counters.
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       wb;
      logic       ld;
   } entry_t;

   typedef struct packed {
      logic [1:0]  sel1;
      logic [1:0]  sel2;
      logic        stall;
      logic [31:0] scnt;
      logic [31:0] fcnt;
   } exp_t;

   entry_t st [2][8];
   int     dep [2] = '{2, 3};
   int     lds [2] = '{2, 3};
   int     m_scnt [2] = '{0, 0};
   int     m_fcnt [2] = '{0, 0};
   exp_t   expq_a[$];
   exp_t   expq_b[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Youngest producer of rs in configuration m: stage number (0 = none).
   function automatic int youngest(input int m, input logic [4:0] rs, output logic ld);
      int k = 0;
      ld = 1'b0;
      for (int i = 1; i <= dep[m]; i++) begin
         if (k == 0 && st[m][i].v && st[m][i].wb && st[m][i].rd != 5'd0 && st[m][i].rd == rs) begin
            k  = i;
            ld = st[m][i].ld;
         end
      end
      return k;
   endfunction

   task automatic model_step(input int m);
      int   k1, k2;
      logic l1, l2, stl;
      exp_t e;
      k1  = youngest(m, ex_rs1, l1);
      k2  = youngest(m, ex_rs2, l2);
      stl = ex_valid && !flush && ((k1 > 0 && l1 && k1 < lds[m]) || (k2 > 0 && l2 && k2 < lds[m]));
      e.sel1  = (ex_valid && !stl) ? 2'(k1) : 2'd0;
      e.sel2  = (ex_valid && !stl) ? 2'(k2) : 2'd0;
      e.stall = stl;
      e.scnt  = 32'(m_scnt[m]);
      e.fcnt  = 32'(m_fcnt[m]);
      if (m == 0) expq_a.push_back(e); else expq_b.push_back(e);
      // State after the coming clock edge.
      if (!rst_n) begin
         for (int i = 1; i <= dep[m]; i++) st[m][i].v = 1'b0;
         m_scnt[m] = 0;
         m_fcnt[m] = 0;
      end else if (pipe_en) begin
         for (int i = dep[m]; i >= 2; i--) st[m][i] = st[m][i-1];
         st[m][1] = '{v: ex_valid && !stl && !flush, rd: ex_rd, wb: ex_wb, ld: ex_load};
         if (stl) m_scnt[m]++;
         else     m_fcnt[m] += int'(e.sel1 != 0) + int'(e.sel2 != 0);
      end
   endtask

   task automatic cyc(input bit r, input bit pe, input bit fl, input bit v,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input bit wb, input bit ld);
      rst_n = r; pipe_en = pe; flush = fl; ex_valid = v;
      ex_rs1 = rs1; ex_rs2 = rs2; ex_rd = rd; ex_wb = wb; ex_load = ld;
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: the outputs for each issued EX state are checked mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (expq_a.size() > 0) begin
         e = expq_a.pop_front();
         chk("A.fwd_sel1", a_sel1, e.sel1);
         chk("A.fwd_sel2", a_sel2, e.sel2);
         chk("A.stall_o", a_stall, e.stall);
`ifdef HAZARD_STATS_EN
         chk("A.stall_cnt", a_scnt, e.scnt);
         chk("A.fwd_cnt", a_fcnt, e.fcnt);
`endif
      end
      if (expq_b.size() > 0) begin
         e = expq_b.pop_front();
         chk("B.fwd_sel1", b_sel1, e.sel1);
         chk("B.fwd_sel2", b_sel2, e.sel2);
         chk("B.stall_o", b_stall, e.stall);
`ifdef HAZARD_STATS_EN
         chk("B.stall_cnt", b_scnt, e.scnt);
         chk("B.fwd_cnt", b_fcnt, e.fcnt);
`endif
      end
   end

   initial begin
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 8; i++) st[m][i] = '0;
      rst_n = 1'b0; pipe_en = 1'b1; flush = 1'b0; ex_valid = 1'b1;
      ex_rs1 = 5'd5; ex_rs2 = 5'd5; ex_rd = 5'd5; ex_wb = 1'b1; ex_load = 1'b0;
      @(posedge clk);
      #1;
      // Reset held with a live writer to x5, then the first reader of x5.
      repeat (3) cyc(0, 1, 0, 1, 5, 5, 5, 1, 0);
      cyc(1, 1, 0, 1, 5, 5, 6, 1, 0);
      // ALU chain: back-to-back, one nop gap, three later.
      cyc(1, 1, 0, 1, 0, 0, 5, 1, 0);
      cyc(1, 1, 0, 1, 5, 0, 8, 1, 0);
      cyc(1, 1, 0, 1, 0, 0, 5, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 5, 0, 8, 1, 0);
      cyc(1, 1, 0, 1, 0, 0, 5, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 5, 0, 8, 1, 0);
      // Youngest wins; x0 writer; non-writing producer.
      cyc(1, 1, 0, 1, 0, 0, 7, 1, 0);
      cyc(1, 1, 0, 1, 0, 0, 7, 1, 0);
      cyc(1, 1, 0, 1, 0, 7, 9, 1, 0);
      cyc(1, 1, 0, 1, 0, 0, 0, 1, 0);
      cyc(1, 1, 0, 1, 0, 0, 4, 1, 0);
      cyc(1, 1, 0, 1, 0, 0, 10, 0, 0);
      cyc(1, 1, 0, 1, 10, 0, 4, 1, 0);
      // Load-use: lw x3 then consumer held in EX while stalled.
      cyc(1, 1, 0, 1, 0, 0, 3, 1, 1);
      repeat (3) cyc(1, 1, 0, 1, 0, 3, 6, 1, 0);
      // Load-use on rs1 with x9.
      cyc(1, 1, 0, 1, 0, 0, 9, 1, 1);
      repeat (3) cyc(1, 1, 0, 1, 9, 0, 6, 1, 0);
      // Freeze for 4 cycles.
      cyc(1, 1, 0, 1, 0, 0, 11, 1, 0);
      repeat (4) cyc(1, 0, 0, 1, 11, 11, 6, 1, 0);
      cyc(1, 1, 0, 1, 11, 11, 6, 1, 0);
      // Flush with a pending load-use.
      cyc(1, 1, 0, 1, 0, 0, 12, 1, 1);
      cyc(1, 1, 1, 1, 0, 12, 13, 1, 0);
      cyc(1, 1, 0, 1, 13, 12, 6, 1, 0);
      cyc(1, 1, 0, 1, 13, 12, 6, 1, 0);
      // Random traffic on a small register set to keep hit rates high.
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(99) >= 2), ($urandom_range(99) < 85), ($urandom_range(99) < 10),
             ($urandom_range(99) < 85), 5'($urandom_range(7)), 5'($urandom_range(7)),
             5'($urandom_range(7)), ($urandom_range(99) < 85), ($urandom_range(99) < 35));
      end
      repeat (2) @(posedge clk);
      chk("queue_drained", expq_a.size() + expq_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
